mmcm_reset_sequencer: RTL and testbench

- Controls power-up and recovery of the MMCM clock generator and runs in the MMCM input reference clock domain (125 MHz).
- Pulses the MMCM reset, waits for lock with a timeout, and retries a bounded number of times.
- Holds the core reset until lock has been stable for a programmed number of cycles.
- Detects lock loss during operation and re-sequences; reports ready, error and retry status.

---
 rtl/mmcm_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mmcm_reset_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reset_sequencer.sv
// Power-up and recovery sequencer for an MMCM: pulses its reset, waits for lock with a bounded
// number of retries, and holds the core reset until lock has stayed stable.
module mmcm_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 125000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2,
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clkin1_i,
  input  logic              async_reset_ni,
  input  logic              locked_i,
  input  logic              req_restart_i,
  output logic              mmcm_rst_o,
  output logic              core_reset_o,
  output logic              ready_o,
  output logic              error_o,
  output logic [RetryW-1:0] retry_cnt_o,
  output logic [2:0]        state_o
);

  localparam int unsigned MaxAB     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > LOCK_STABLE_CYCLES) ? MaxAB : LOCK_STABLE_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0]   PulseLast   = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPulse    = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StError    = 3'd4
  } state_e;

  // Reset asserts asynchronously, deasserts on the second clock edge after release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clkin1_i or negedge async_reset_ni) begin
    if (!async_reset_ni) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;

  always_ff @(posedge clkin1_i or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              mmcm_rst_q, mmcm_rst_d;
  logic              core_reset_q, core_reset_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    unique case (state_q)
      StPulse: begin
        if (cnt_q == PulseLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock seen on the timeout cycle still wins over the timeout.
        if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == RetryMax) begin
            state_d = StError;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StPulse;
          end
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          retry_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_s) state_d = StPulse;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StPulse;
      end
    endcase

    if (req_restart_i) begin
      state_d = StPulse;
      retry_d = '0;
    end

    // A restart inside StPulse must also rewind the pulse count.
    if (req_restart_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    mmcm_rst_d   = (state_d == StPulse) || (state_d == StError);
    core_reset_d = (state_d != StRun);
    ready_d      = (state_d == StRun);
    error_d      = (state_d == StError);
  end

  always_ff @(posedge clkin1_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StPulse;
      cnt_q        <= '0;
      retry_q      <= '0;
      mmcm_rst_q   <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      mmcm_rst_q   <= mmcm_rst_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  assign mmcm_rst_o   = mmcm_rst_q;
  assign core_reset_o = core_reset_q;
  assign ready_o      = ready_q;
  assign error_o      = error_q;
  assign retry_cnt_o  = retry_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Self-checking bench for mmcm_reset_sequencer: directed scenarios plus random lock/restart/reset
// stimulus, all compared against a cycle-level behavioural model.
module tb_mmcm_reset_sequencer;

  localparam int unsigned RstPulse  = 4;
  localparam int unsigned Timeout   = 20;
  localparam int unsigned Stable    = 8;
  localparam int unsigned MaxRetry  = 2;
  localparam int unsigned SyncStg   = 2;
  localparam int unsigned RetryW    = $clog2(MaxRetry + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              locked = 1'b0;
  logic              req = 1'b0;
  logic              mmcm_rst, core_reset, ready, error;
  logic [RetryW-1:0] retry;
  logic [2:0]        state;

  always #5 clk = ~clk;

  mmcm_reset_sequencer #(
    .RST_PULSE_CYCLES   (RstPulse),
    .LOCK_TIMEOUT_CYCLES(Timeout),
    .LOCK_STABLE_CYCLES (Stable),
    .MAX_RETRIES        (MaxRetry),
    .SYNC_STAGES        (SyncStg)
  ) u_dut (
    .clkin1_i      (clk),
    .async_reset_ni(rst_n),
    .locked_i      (locked),
    .req_restart_i (req),
    .mmcm_rst_o    (mmcm_rst),
    .core_reset_o  (core_reset),
    .ready_o       (ready),
    .error_o       (error),
    .retry_cnt_o   (retry),
    .state_o       (state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0=pulse 1=wait 2=stable 3=run 4=error, elapsed cycles in phase.
  int m_state, m_cnt, m_retry, m_pend;
  int lq[$];

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_retry = 0;
    m_pend  = 2;
    lq = {};
    for (int i = 0; i < SyncStg; i++) lq.push_back(0);
  endtask

  task automatic model_step(input logic l, input logic r);
    int lock_s;
    int nxt;
    if (m_pend > 0) begin
      m_pend--;
      return;
    end
    lock_s = lq.pop_front();
    lq.push_back(int'(l));
    nxt = m_state;
    case (m_state)
      0: if (m_cnt == RstPulse - 1) nxt = 1;
      1: begin
        if (lock_s != 0) nxt = 2;
        else if (m_cnt == Timeout - 1) begin
          if (m_retry == MaxRetry) nxt = 4;
          else begin
            m_retry++;
            nxt = 0;
          end
        end
      end
      2: begin
        if (lock_s == 0) nxt = 1;
        else if (m_cnt == Stable - 1) begin
          m_retry = 0;
          nxt = 3;
        end
      end
      3: if (lock_s == 0) nxt = 0;
      default: nxt = 4;
    endcase
    if (r) begin
      nxt = 0;
      m_retry = 0;
    end
    if (r || nxt != m_state) m_cnt = 0;
    else m_cnt++;
    m_state = nxt;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".mmcm_rst"}, 32'(mmcm_rst), 32'(m_state == 0 || m_state == 4));
    check_eq({tag, ".core_reset"}, 32'(core_reset), 32'(m_state != 3));
    check_eq({tag, ".ready"}, 32'(ready), 32'(m_state == 3));
    check_eq({tag, ".error"}, 32'(error), 32'(m_state == 4));
    check_eq({tag, ".retry"}, 32'(retry), 32'(m_retry));
    check_eq({tag, ".state"}, 32'(state), 32'(m_state));
  endtask

  // Called at a negedge; inputs hold across the following posedge, outputs checked at next negedge.
  task automatic tick(input logic l, input logic r, input string tag);
    locked = l;
    req    = r;
    @(posedge clk);
    model_step(l, r);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Counts consecutive observations with mmcm_rst == want, ticking with lock input l.
  task automatic run_while(input logic want, input logic l, input string tag, output int n);
    n = 0;
    while (mmcm_rst === want && n < 200) begin
      n++;
      tick(l, 1'b0, tag);
    end
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".noclk"});
    @(negedge clk);
    compare_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, k, r0, seg_len;
    logic seg_val, saw_wait, saw_rst;

    model_reset();
    repeat (2) @(negedge clk);
    compare_all("por");
    rst_n = 1'b1;

    // 1: nominal bring-up (two sync cycles precede the 4-cycle pulse)
    run_while(1'b1, 1'b0, "t1", n);
    check_eq("t1_first_pulse", n, RstPulse + 2);
    repeat (4) tick(1'b0, 1'b0, "t1");
    k = 0;
    do begin
      tick(1'b1, 1'b0, "t1");
      k++;
    end while (!ready && k < 100);
    check_eq("t1_lock_to_ready", k, SyncStg + Stable + 1);
    check_eq("t1_core_reset", 32'(core_reset), 0);
    check_eq("t1_retry", 32'(retry), 0);

    // 4: lock loss in run
    k = 0;
    do begin
      tick(1'b0, 1'b0, "t4");
      k++;
    end while (!core_reset && k < 50);
    check_eq("t4_loss_to_core_reset", k, SyncStg + 1);
    check_eq("t4_ready_low", 32'(ready), 0);
    run_while(1'b1, 1'b0, "t4", n);
    check_eq("t4_pulse_width", n, RstPulse);
    k = 0;
    do begin
      tick(1'b1, 1'b0, "t4");
      k++;
    end while (!ready && k < 100);
    check_eq("t4_recover_ready", k, SyncStg + Stable + 1);

    // 3: one-cycle lock glitch seen at stable count 5
    k = 0;
    while (!mmcm_rst && k < 50) begin
      tick(1'b0, 1'b0, "t3");
      k++;
    end
    run_while(1'b1, 1'b0, "t3", n);
    k = 0;
    while (state !== 3'd2 && k < 50) begin
      tick(1'b1, 1'b0, "t3");
      k++;
    end
    repeat (3) tick(1'b1, 1'b0, "t3");
    r0 = int'(retry);
    tick(1'b0, 1'b0, "t3");
    k = 1;
    saw_wait = 1'b0;
    saw_rst  = 1'b0;
    while (!ready && k < 100) begin
      tick(1'b1, 1'b0, "t3");
      k++;
      if (state === 3'd1) saw_wait = 1'b1;
      if (mmcm_rst === 1'b1) saw_rst = 1'b1;
    end
    check_eq("t3_back_to_wait", 32'(saw_wait), 1);
    check_eq("t3_no_mmcm_pulse", 32'(saw_rst), 0);
    check_eq("t3_retry_kept", 32'(retry), r0);
    check_eq("t3_glitch_to_ready", k, 12);

    // 2: no lock at all -> three pulses, then error with MMCM parked
    k = 0;
    while (!mmcm_rst && k < 50) begin
      tick(1'b0, 1'b0, "t2");
      k++;
    end
    for (int p = 0; p <= int'(MaxRetry); p++) begin
      check_eq("t2_retry_step", 32'(retry), p);
      run_while(1'b1, 1'b0, "t2", n);
      check_eq("t2_pulse_width", n, RstPulse);
      run_while(1'b0, 1'b0, "t2", n);
      check_eq("t2_low_gap", n, Timeout);
    end
    check_eq("t2_error", 32'(error), 1);
    check_eq("t2_retry_max", 32'(retry), MaxRetry);
    repeat (30) tick(1'b0, 1'b0, "t2");
    check_eq("t2_parked", 32'(mmcm_rst), 1);

    // 5: restart from error, then restart colliding with a timeout
    tick(1'b0, 1'b1, "t5");
    check_eq("t5_error_clr", 32'(error), 0);
    check_eq("t5_retry_clr", 32'(retry), 0);
    run_while(1'b1, 1'b0, "t5", n);
    check_eq("t5_pulse_width", n, RstPulse);
    run_while(1'b0, 1'b0, "t5", n);
    check_eq("t5_retry_after_timeout", 32'(retry), 1);
    run_while(1'b1, 1'b0, "t5", n);
    repeat (Timeout - 1) tick(1'b0, 1'b0, "t5");
    tick(1'b0, 1'b1, "t5");
    check_eq("t5_restart_beats_timeout", 32'(retry), 0);
    check_eq("t5_restart_state", 32'(state), 0);

    // 6: async reset while stable
    k = 0;
    while (state !== 3'd2 && k < 100) begin
      tick(1'b1, 1'b0, "t6");
      k++;
    end
    repeat (2) tick(1'b1, 1'b0, "t6");
    async_reset_pulse("t6_rst");
    k = 0;
    while (!ready && k < 100) begin
      tick(1'b1, 1'b0, "t6");
      k++;
    end
    check_eq("t6_ready_after_reset", 32'(ready), 1);

    // Random lock segments with occasional restarts and resets
    seg_len = 0;
    seg_val = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (seg_len == 0) begin
        seg_val = ($urandom_range(0, 2) != 0);
        seg_len = $urandom_range(1, 60);
      end
      seg_len--;
      if ($urandom_range(0, 499) == 0) begin
        async_reset_pulse("rnd_rst");
      end else begin
        tick(seg_val, $urandom_range(0, 79) == 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
